transmite_cores: RTL

//  Reader side of the color memory filled by the color-identification unit. On iniciar, walks the

---
 rtl/transmite_cores_pkg.sv | 52 +++++
 rtl/transmite_cores_if.sv | 28 ++
 rtl/transmite_cores_uc.sv | 125 ++++++++++++
 rtl/transmite_cores.sv | 100 ++++++++++
 4 files changed

// File: rtl/transmite_cores_pkg.sv
// Shared types for the color-memory reader: FSM state codes,
// color codes, ASCII constants and the color-to-letter map.
package transmite_cores_pkg;

   typedef enum logic [3:0] {
      INICIAL         = 4'd0,
      PREPARA         = 4'd1,
      LE_COR          = 4'd2,
      ESPERA_LEITURA  = 4'd3,
      CONVERTE        = 4'd4,
      ENVIA           = 4'd5,
      ESPERA_TX       = 4'd6,
      ATUALIZA_COLUNA = 4'd7,
      ATUALIZA_LINHA  = 4'd8,
      ENVIA_FIM       = 4'd9,
      ESPERA_FIM      = 4'd10,
      ENVIA_CHK       = 4'd11,
      FIM             = 4'd12,
      ESPERA_CHK      = 4'd13
   } estado_t;

   localparam logic [2:0] COR_BRANCO   = 3'd0;
   localparam logic [2:0] COR_AMARELO  = 3'd1;
   localparam logic [2:0] COR_VERMELHO = 3'd2;
   localparam logic [2:0] COR_LARANJA  = 3'd3;
   localparam logic [2:0] COR_VERDE    = 3'd4;
   localparam logic [2:0] COR_AZUL     = 3'd5;

   localparam logic [7:0] ASCII_W  = 8'h57;
   localparam logic [7:0] ASCII_Y  = 8'h59;
   localparam logic [7:0] ASCII_R  = 8'h52;
   localparam logic [7:0] ASCII_O  = 8'h4F;
   localparam logic [7:0] ASCII_G  = 8'h47;
   localparam logic [7:0] ASCII_B  = 8'h42;
   localparam logic [7:0] ASCII_QM = 8'h3F;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   function automatic logic [7:0] mapa_cor(input logic [2:0] cor);
      logic [7:0] letra;
      case (cor)
         COR_BRANCO:   letra = ASCII_W;
         COR_AMARELO:  letra = ASCII_Y;
         COR_VERMELHO: letra = ASCII_R;
         COR_LARANJA:  letra = ASCII_O;
         COR_VERDE:    letra = ASCII_G;
         COR_AZUL:     letra = ASCII_B;
         default:      letra = ASCII_QM;
      endcase
      return letra;
   endfunction

endpackage

// File: rtl/transmite_cores_if.sv
// Bundle between the reader core and its environment
// (start/done, color-memory read port, serial TX handshake, debug).
interface transmite_cores_if #(
   parameter int COR_W  = 3,
   parameter int ADDR_W = 4
);
   logic              iniciar;
   logic [COR_W-1:0]  cor_rdata;
   logic              tx_pronto;
   logic [ADDR_W-1:0] cor_addr;
   logic              cor_re;
   logic [7:0]        tx_dado;
   logic              tx_partida;
   logic              pronto;
   logic [3:0]        db_estado;

   modport master (
      input  iniciar, cor_rdata, tx_pronto,
      output cor_addr, cor_re, tx_dado,
      output tx_partida, pronto, db_estado
   );

   modport slave (
      output iniciar, cor_rdata, tx_pronto,
      input  cor_addr, cor_re, tx_dado,
      input  tx_partida, pronto, db_estado
   );
endinterface

// File: rtl/transmite_cores_uc.sv
// Control FSM of the color reader. Optional CHECKSUM_EN appends
// an XOR checksum byte after the line feed.
module transmite_cores_uc (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       tx_pronto,
   input  logic       ultimo,
   input  logic       fim_coluna,
   output logic       limpa,
   output logic       inc_coluna,
   output logic       inc_linha,
   output logic       carrega_cor,
   output logic       carrega_lf,
`ifdef CHECKSUM_EN
   output logic       carrega_chk,
`endif
   output logic       cor_re,
   output logic       tx_partida,
   output logic       pronto,
   output logic [3:0] db_estado
);
   import transmite_cores_pkg::*;

   estado_t estado;
   estado_t proximo;

   // state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) estado <= INICIAL;
      else       estado <= proximo;
   end

   // next state and Moore outputs; the byte register is loaded on
   // the way into a send state so it is valid when partida rises
   always_comb begin
      proximo     = estado;
      limpa       = 1'b0;
      inc_coluna  = 1'b0;
      inc_linha   = 1'b0;
      carrega_cor = 1'b0;
      carrega_lf  = 1'b0;
`ifdef CHECKSUM_EN
      carrega_chk = 1'b0;
`endif
      cor_re      = 1'b0;
      tx_partida  = 1'b0;
      pronto      = 1'b0;
      case (estado)
         INICIAL:
            if (iniciar) proximo = PREPARA;
         PREPARA: begin
            limpa   = 1'b1;
            proximo = LE_COR;
         end
         LE_COR: begin
            cor_re  = 1'b1;
            proximo = ESPERA_LEITURA;
         end
         ESPERA_LEITURA:
            proximo = CONVERTE;
         CONVERTE: begin
            carrega_cor = 1'b1;
            proximo     = ENVIA;
         end
         ENVIA: begin
            tx_partida = 1'b1;
            proximo    = ESPERA_TX;
         end
         ESPERA_TX:
            if (tx_pronto) begin
               if (ultimo) begin
                  carrega_lf = 1'b1;
                  proximo    = ENVIA_FIM;
               end else if (fim_coluna) begin
                  proximo = ATUALIZA_LINHA;
               end else begin
                  proximo = ATUALIZA_COLUNA;
               end
            end
         ATUALIZA_COLUNA: begin
            inc_coluna = 1'b1;
            proximo    = LE_COR;
         end
         ATUALIZA_LINHA: begin
            inc_linha = 1'b1;
            proximo   = LE_COR;
         end
         ENVIA_FIM: begin
            tx_partida = 1'b1;
            proximo    = ESPERA_FIM;
         end
         ESPERA_FIM:
            if (tx_pronto) begin
`ifdef CHECKSUM_EN
               carrega_chk = 1'b1;
               proximo     = ENVIA_CHK;
`else
               proximo = FIM;
`endif
            end
`ifdef CHECKSUM_EN
         ENVIA_CHK: begin
            tx_partida = 1'b1;
            proximo    = ESPERA_CHK;
         end
         ESPERA_CHK:
            if (tx_pronto) proximo = FIM;
`endif
         FIM: begin
            pronto  = 1'b1;
            proximo = INICIAL;
         end
         default:
            proximo = INICIAL;
      endcase
   end

`ifdef CHECKSUM_EN
   assign db_estado = (estado == ESPERA_CHK) ? 4'd10 : estado;
`else
   assign db_estado = estado;
`endif

endmodule

// File: rtl/transmite_cores.sv
// Color-memory reader: walks the grid row-major and sends one
// ASCII letter per facelet, then LF (checksum with CHECKSUM_EN).
module transmite_cores #(
   parameter int LINHAS  = 3,
   parameter int COLUNAS = 3,
   parameter int COR_W   = 3,
   parameter int ADDR_W  = 4
) (
   input  logic              clock,
   input  logic              reset,
   transmite_cores_if.master bus
);
   import transmite_cores_pkg::*;

   localparam logic [ADDR_W-1:0] NCOL = ADDR_W'(COLUNAS);
   localparam logic [ADDR_W-1:0] ULT_C = ADDR_W'(COLUNAS - 1);
   localparam logic [ADDR_W-1:0] ULT_L = ADDR_W'(LINHAS - 1);

   logic [ADDR_W-1:0] linha;
   logic [ADDR_W-1:0] coluna;
   logic [7:0]        letra;
   logic              limpa;
   logic              inc_coluna;
   logic              inc_linha;
   logic              carrega_cor;
   logic              carrega_lf;
   logic              fim_coluna;
   logic              ultimo;
`ifdef CHECKSUM_EN
   logic              carrega_chk;
   logic [7:0]        checksum;
`endif

   assign fim_coluna   = (coluna == ULT_C);
   assign ultimo       = fim_coluna && (linha == ULT_L);
   assign bus.cor_addr = linha * NCOL + coluna;
   assign letra        = mapa_cor(bus.cor_rdata[2:0]);

   transmite_cores_uc uc (
      .clock       (clock),
      .reset       (reset),
      .iniciar     (bus.iniciar),
      .tx_pronto   (bus.tx_pronto),
      .ultimo      (ultimo),
      .fim_coluna  (fim_coluna),
      .limpa       (limpa),
      .inc_coluna  (inc_coluna),
      .inc_linha   (inc_linha),
      .carrega_cor (carrega_cor),
      .carrega_lf  (carrega_lf),
`ifdef CHECKSUM_EN
      .carrega_chk (carrega_chk),
`endif
      .cor_re      (bus.cor_re),
      .tx_partida  (bus.tx_partida),
      .pronto      (bus.pronto),
      .db_estado   (bus.db_estado)
   );

   // row/column counters; the FSM only steps them inside the grid
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         linha  <= '0;
         coluna <= '0;
      end else if (limpa) begin
         linha  <= '0;
         coluna <= '0;
      end else if (inc_coluna) begin
         coluna <= coluna + 1'b1;
      end else if (inc_linha) begin
         coluna <= '0;
         linha  <= linha + 1'b1;
      end
   end

   // outgoing byte: mapped color, line feed or checksum
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bus.tx_dado <= '0;
      end else if (carrega_cor) begin
         bus.tx_dado <= letra;
      end else if (carrega_lf) begin
         bus.tx_dado <= ASCII_LF;
`ifdef CHECKSUM_EN
      end else if (carrega_chk) begin
         bus.tx_dado <= checksum;
`endif
      end
   end

`ifdef CHECKSUM_EN
   // running XOR over the color bytes of the current pass
   always_ff @(posedge clock or posedge reset) begin
      if (reset)            checksum <= '0;
      else if (limpa)       checksum <= '0;
      else if (carrega_cor) checksum <= checksum ^ letra;
   end
`endif

endmodule
